golden_nonce_reporter: RTL and testbench
========================================

# golden_nonce_reporter

Captures golden nonces produced by the mining core (`fpgaminer_top`), corrects them for hashing-pipeline offset, and buffers them in a small FIFO. It then streams each nonce out as four bytes, MSB first, over a valid/ready byte interface to the host-link transmitter. It sits directly downstream of the core's golden-nonce output, so back-to-back hits cannot be lost while the serial link is busy; if the FIFO fills, the loss is flagged.

## Interface
- `DEPTH_LOG2`, 2: FIFO depth is 2^DEPTH_LOG2 entries.
- `NONCE_ADJUST`, 32'd0: constant subtracted (mod 2^32) from every captured nonce. It compensates for the core's pipeline latency.
- `clk` in 1: sole clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `golden_nonce_in` in 32: raw nonce from the core; valid only while `golden_valid_in` is high.
- `golden_valid_in` in 1: one push per cycle that it is high.
- `tx_data` out 8: current byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: consumer accepts the byte this cycle.
- `fifo_count` out DEPTH_LOG2+1: number of stored entries.
- `overflow` out 1: sticky flag; a nonce was dropped.

## Operation
- **Push:** when `golden_valid_in`=1, write `golden_nonce_in - NONCE_ADJUST` (32-bit wrap) at the write pointer, advance the pointer, and increment the count.
- **Full:** a push while `fifo_count` = 2^DEPTH_LOG2, with no pop in the same cycle, is dropped.
  - Storage and pointers are unchanged.
  - `overflow` is set to 1 and stays 1 until `reset`.
- **Pointers:** DEPTH_LOG2 bits wide and wrap naturally. Full and empty are derived from `fifo_count` only.
- **Serializer FSM states:**
  - IDLE: `tx_valid`=0. If `fifo_count`≠0, pop the head into a 32-bit shift register, set byte_idx=0, and go to SEND.
  - SEND: `tx_valid`=1 and `tx_data`=shift[31:24].
    - On `tx_valid && tx_ready`: if byte_idx=3, go to IDLE. Otherwise shift left by 8 and increment byte_idx.
    - With `tx_ready`=0, hold `tx_data` and the state unchanged, for any number of cycles.
- **Simultaneous push and pop:**
  - Both take effect and `fifo_count` is unchanged.
  - When full, the push is accepted, because the pop frees the slot in the same cycle. `overflow` is not set.
- **Byte order:** nonce 0xAABBCCDD is sent as AA, BB, CC, DD.
- **Reset** (including in the middle of a transfer):
  - FIFO is emptied and pointers are zeroed.
  - `fifo_count`=0, `overflow`=0.
  - FSM goes to IDLE; `tx_valid`=0, `tx_data`=0.
  - A partially sent nonce is discarded.
  - A push in the same cycle as `reset` is ignored.

## Timing
- **Push visibility:** a push at edge N is visible in `fifo_count` after edge N.
- **Pop:** the IDLE→SEND pop occurs at edge N+1 at the earliest. `tx_valid`=1 with the first byte after that edge.
  - Latency from the `golden_valid_in` cycle to the first `tx_valid` cycle is 2 cycles with an empty FIFO and idle FSM.
- **Bytes:** one byte per accepted handshake. Four bytes take at least 4 cycles with `tx_ready` held high.
- **Gap between nonces:** after the 4th byte is accepted, there is exactly one cycle with `tx_valid`=0 (the IDLE cycle) before the next nonce begins.
  - Minimum sustained period is 5 cycles per nonce.
- **Stability:** `tx_data` and `tx_valid` are registered outputs and never change while `tx_valid`=1 and `tx_ready`=0.
- **Count update:** `fifo_count` updates on the same edge as the push or pop.

## Test plan
- **Single nonce:** NONCE_ADJUST=0; push 0x0e33337a with `tx_ready`=1.
  - `tx_valid` rises 2 cycles later.
  - Bytes 0e, 33, 33, 7a on consecutive cycles, then `tx_valid`=0 for one cycle.
- **Adjustment wrap:** NONCE_ADJUST=32'h00000003; push 0x00000001.
  - Output bytes are ff, ff, ff, fe.
- **Backpressure:** push 0x12345678 and hold `tx_ready`=0 for 10 cycles after `tx_valid` rises.
  - `tx_data` stays 12 throughout.
  - With `tx_ready` then toggling 1/0, the bytes 34, 56, 78 each appear only after a handshake.
- **Overflow:** DEPTH_LOG2=2, `tx_ready`=0; push 6 distinct nonces on consecutive cycles.
  - 1 nonce sits in the shift register and 4 are in the FIFO; the 6th is dropped.
  - `fifo_count`=4 and `overflow`=1.
  - Draining yields the first 5 nonces in order, and `overflow` stays 1.
- **Full push+pop:** with the FIFO full and FSM in IDLE, push on the pop cycle.
  - `fifo_count` stays 4, `overflow` stays 0, and the new nonce is the last one output.
- **Reset mid-transfer:** assert `reset` for 1 cycle after the 2nd byte is accepted, with 2 entries queued.
  - Next cycle: `tx_valid`=0, `fifo_count`=0, `overflow`=0.
  - No further bytes until a new push, which then outputs normally.

Source files
------------

// File: rtl/golden_nonce_reporter.sv
// Golden-nonce capture FIFO with pipeline-offset correction and an MSB-first
// byte serializer over a valid/ready interface.
module golden_nonce_reporter #(
   parameter int unsigned DEPTH_LOG2   = 2,
   parameter logic [31:0] NONCE_ADJUST = 32'd0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           golden_nonce_in,
   input  logic                  golden_valid_in,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  overflow
);

   localparam int unsigned          DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]  FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [31:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  r_wptr;
   logic [DEPTH_LOG2-1:0]  r_rptr;
   logic [DEPTH_LOG2:0]    r_count;
   logic                   r_overflow;
   logic [31:0]            r_shift;
   logic [1:0]             r_byte_idx;

   logic                   w_full;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_hs;
   logic                   w_drop;

   always_comb begin
      w_full       = (r_count == FULL_CNT);
      w_pop        = 1'b0;
      w_hs         = 1'b0;
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop        = 1'b1;
               w_next_state = S_SEND;
            end
         end
         S_SEND: begin
            w_hs = tx_ready;
            if (tx_ready && (r_byte_idx == 2'd3))
               w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
      // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
      w_push = golden_valid_in && (!w_full || w_pop);
      w_drop = golden_valid_in && w_full && !w_pop;
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push)
         r_mem[r_wptr] <= golden_nonce_in - NONCE_ADJUST;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_shift    <= '0;
         r_byte_idx <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
         if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
            2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) r_overflow <= 1'b1;
         if (w_pop) begin
            r_shift    <= r_mem[r_rptr];
            r_byte_idx <= '0;
         end else if (w_hs && (r_byte_idx != 2'd3)) begin
            r_shift    <= {r_shift[23:0], 8'h00};
            r_byte_idx <= r_byte_idx + 2'd1;
         end
      end
   end

   assign tx_valid   = (r_state == S_SEND);
   assign tx_data    = r_shift[31:24];
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed bench for golden_nonce_reporter: cycle table for single-nonce and
// backpressure traffic, plus sequences for wrap, full FIFO, overflow and reset.
module tb_golden_nonce_reporter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] n0, n3;
   logic        v0, v3, rdy, rdy3;
   logic [7:0]  txd0, txd3;
   logic        txv0, txv3;
   logic [2:0]  cnt0, cnt3;
   logic        ovf0, ovf3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   golden_nonce_reporter #(.DEPTH_LOG2(2), .NONCE_ADJUST(32'd0)) dut0 (
      .clk(clk), .reset(rst), .golden_nonce_in(n0), .golden_valid_in(v0),
      .tx_data(txd0), .tx_valid(txv0), .tx_ready(rdy),
      .fifo_count(cnt0), .overflow(ovf0));

   golden_nonce_reporter #(.DEPTH_LOG2(2), .NONCE_ADJUST(32'h00000003)) dut3 (
      .clk(clk), .reset(rst), .golden_nonce_in(n3), .golden_valid_in(v3),
      .tx_data(txd3), .tx_valid(txv3), .tx_ready(rdy3),
      .fifo_count(cnt3), .overflow(ovf3));

   typedef struct {
      logic        v;
      logic [31:0] n;
      logic        r;
      logic        ev;
      logic [7:0]  ed;
      logic [2:0]  ec;
      logic        eo;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] got[$];

   function automatic void add(logic v, logic [31:0] n, logic r, logic ev,
                               logic [7:0] ed, logic [2:0] ec, logic eo);
      vec_t e;
      e.v = v; e.n = n; e.r = r; e.ev = ev; e.ed = ed; e.ec = ec; e.eo = eo;
      tbl.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Collects bytes from dut0 with tx_ready high; a timeout counts as a failure.
   task automatic drain(input int nbytes, input int budget);
      int cyc;
      cyc = 0;
      got.delete();
      rdy = 1'b1;
      while (got.size() < nbytes && cyc < budget) begin
         if (txv0) got.push_back(txd0);
         step();
         cyc++;
      end
      chk("drain_bytes", got.size(), nbytes);
   endtask

   function automatic logic [31:0] word_at(int k);
      if (got.size() < 4 * k + 4) return 32'hxxxxxxxx;
      return {got[4*k], got[4*k+1], got[4*k+2], got[4*k+3]};
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] nn [6];
      int k;

      rst = 1'b1; v0 = 1'b0; v3 = 1'b0; n0 = '0; n3 = '0; rdy = 1'b0; rdy3 = 1'b0;
      step(); step();
      chk("rst_valid", txv0, 1'b0);
      chk("rst_data",  txd0, 8'h00);
      chk("rst_count", cnt0, 3'd0);
      chk("rst_ovf",   ovf0, 1'b0);
      rst = 1'b0;

      // single nonce, then backpressure; each row is checked after its edge
      add(1, 32'h0e33337a, 1, 0, 8'h00, 1, 0);
      add(0, 0,            1, 1, 8'h0e, 0, 0);
      add(0, 0,            1, 1, 8'h33, 0, 0);
      add(0, 0,            1, 1, 8'h33, 0, 0);
      add(0, 0,            1, 1, 8'h7a, 0, 0);
      add(0, 0,            1, 0, 8'h00, 0, 0);
      add(0, 0,            1, 0, 8'h00, 0, 0);
      add(1, 32'h12345678, 0, 0, 8'h00, 1, 0);
      add(0, 0,            0, 1, 8'h12, 0, 0);
      for (int i = 0; i < 10; i++) add(0, 0, 0, 1, 8'h12, 0, 0);
      add(0, 0, 1, 1, 8'h34, 0, 0);
      add(0, 0, 0, 1, 8'h34, 0, 0);
      add(0, 0, 1, 1, 8'h56, 0, 0);
      add(0, 0, 0, 1, 8'h56, 0, 0);
      add(0, 0, 1, 1, 8'h78, 0, 0);
      add(0, 0, 0, 1, 8'h78, 0, 0);
      add(0, 0, 1, 0, 8'h00, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         v0 = tbl[i].v; n0 = tbl[i].n; rdy = tbl[i].r;
         step();
         chk($sformatf("tbl%0d_valid", i), txv0, tbl[i].ev);
         chk($sformatf("tbl%0d_count", i), cnt0, tbl[i].ec);
         chk($sformatf("tbl%0d_ovf", i),   ovf0, tbl[i].eo);
         if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), txd0, tbl[i].ed);
      end
      v0 = 1'b0;

      // adjustment wraps modulo 2^32: 1 - 3 = 0xfffffffe
      rdy3 = 1'b1; v3 = 1'b1; n3 = 32'h00000001;
      step();
      v3 = 1'b0;
      got.delete();
      k = 0;
      while (got.size() < 4 && k < 10) begin
         if (txv3) got.push_back(txd3);
         step();
         k++;
      end
      chk("wrap_bytes", got.size(), 4);
      chk("wrap_word", word_at(0), 32'hfffffffe);

      // full FIFO with FSM idle: push in the pop cycle is kept
      rdy = 1'b0; v0 = 1'b1;
      nn[0] = 32'ha0a1a2a3; nn[1] = 32'hb0b1b2b3; nn[2] = 32'hc0c1c2c3;
      nn[3] = 32'hd0d1d2d3; nn[4] = 32'he0e1e2e3; nn[5] = 32'hf0f1f2f3;
      for (int i = 0; i < 5; i++) begin
         n0 = nn[i];
         step();
      end
      v0 = 1'b0;
      chk("full_count", cnt0, 3'd4);
      chk("full_ovf0", ovf0, 1'b0);
      rdy = 1'b1;
      k = 0;
      while (txv0 !== 1'b0 && k < 20) begin
         step();
         k++;
      end
      chk("full_idle_reached", txv0, 1'b0);
      v0 = 1'b1; n0 = nn[5];
      step();
      v0 = 1'b0;
      chk("pushpop_count", cnt0, 3'd4);
      chk("pushpop_ovf", ovf0, 1'b0);
      drain(20, 60);
      for (int i = 0; i < 5; i++) chk($sformatf("pushpop_word%0d", i), word_at(i), nn[i+1]);

      // overflow: 1 in shift register, 4 queued, 6th dropped
      rdy = 1'b0;
      step();
      nn[0] = 32'h11111111; nn[1] = 32'h22222222; nn[2] = 32'h33333333;
      nn[3] = 32'h44444444; nn[4] = 32'h55555555; nn[5] = 32'h66666666;
      v0 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n0 = nn[i];
         step();
      end
      v0 = 1'b0;
      chk("ovf_count", cnt0, 3'd4);
      chk("ovf_flag", ovf0, 1'b1);
      chk("ovf_head", txd0, 8'h11);
      drain(20, 60);
      for (int i = 0; i < 5; i++) chk($sformatf("ovf_word%0d", i), word_at(i), nn[i]);
      step(); step();
      chk("ovf_sticky", ovf0, 1'b1);
      chk("ovf_extra_valid", txv0, 1'b0);

      // reset after 2nd byte accepted with two entries queued (overflow still set)
      rdy = 1'b1; v0 = 1'b1; n0 = 32'h9a9b9c9d;
      step();
      n0 = 32'h8a8b8c8d;
      step();
      n0 = 32'h7a7b7c7d;
      step();
      v0 = 1'b0;
      chk("mid_count", cnt0, 3'd2);
      chk("mid_byte1", txd0, 8'h9b);
      step();
      rst = 1'b1; v0 = 1'b1; n0 = 32'hdeadbeef;
      step();
      rst = 1'b0; v0 = 1'b0;
      chk("mrst_valid", txv0, 1'b0);
      chk("mrst_data", txd0, 8'h00);
      chk("mrst_count", cnt0, 3'd0);
      chk("mrst_ovf", ovf0, 1'b0);
      k = 0;
      for (int i = 0; i < 8; i++) begin
         if (txv0 !== 1'b0 || cnt0 !== 3'd0) k++;
         step();
      end
      chk("mrst_quiet", k, 0);
      v0 = 1'b1; n0 = 32'h0badf00d;
      step();
      v0 = 1'b0;
      drain(4, 12);
      chk("mrst_new_word", word_at(0), 32'h0badf00d);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
